// File: rtl/tybec_axis_pkg.sv
// Shared types and constants for the AXI-stream input side of the tybec kernel wrapper.
// Beat widths scale with the generated kernel's vector width.
package tybec_axis_pkg;

    localparam int TY_MAX_STREAMW = 512;
    localparam int TY_GVECT       = 1;
    localparam int TY_DATA_WIDTH  = 32 * TY_GVECT;

    typedef logic [TY_DATA_WIDTH-1:0] ty_beat_t;

    // One extra wrap bit tells full apart from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/tybec_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered full flag.
// Full resets high so nothing is accepted until the cycle after reset releases.
module tybec_sync_fifo
    import tybec_axis_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [PW-1:0]    wp_n;
    logic [PW-1:0]    rp_n;
    logic             do_wr;
    logic             do_rd;
    logic             full_n;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_comb begin
        wp_n   = wp + {{(PW-1){1'b0}}, do_wr};
        rp_n   = rp + {{(PW-1){1'b0}}, do_rd};
        full_n = (wp_n[PW-1] != rp_n[PW-1]) &&
                 (wp_n[PW-2:0] == rp_n[PW-2:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp   <= '0;
            rp   <= '0;
            full <= 1'b1;
        end else begin
            wp   <= wp_n;
            rp   <= rp_n;
            full <= full_n;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wp[PW-2:0]] <= wr_data;
    end

    assign empty   = (wp == rp);
    assign rd_data = mem[rp[PW-2:0]];

endmodule

// File: rtl/axis_chan_align.sv
// Buffers skewed AXI4-Stream channels and releases them only as lane-aligned beats.
// All FIFOs pop together, so no channel ever advances alone.
module axis_chan_align
    import tybec_axis_pkg::*;
#(
    parameter int C_DATA_WIDTH   = TY_DATA_WIDTH,
    parameter int C_NUM_CHANNELS = 2,
    parameter int C_FIFO_DEPTH   = 4
) (
    input  logic                                         aclk,
    input  logic                                         areset,
    input  logic [C_NUM_CHANNELS-1:0]                    s_tvalid,
    input  logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  s_tdata,
    output logic [C_NUM_CHANNELS-1:0]                    s_tready,
    output logic [C_NUM_CHANNELS-1:0]                    m_tvalid,
    output logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  m_tdata,
    input  logic [C_NUM_CHANNELS-1:0]                    m_tready,
    output logic [31:0]                                  beat_count
);

    logic [C_NUM_CHANNELS-1:0] full;
    logic [C_NUM_CHANNELS-1:0] empty;
    logic                      avail;
    logic                      fire;

    // Valid is held low during reset so no stale head leaks out.
    assign avail    = ~areset & ~|empty;
    assign fire     = avail & (&m_tready);
    assign m_tvalid = {C_NUM_CHANNELS{avail}};
    assign s_tready = ~full;

    for (genvar i = 0; i < C_NUM_CHANNELS; i++) begin : g_ch
        tybec_sync_fifo #(
            .WIDTH (C_DATA_WIDTH),
            .DEPTH (C_FIFO_DEPTH)
        ) u_fifo (
            .clk     (aclk),
            .rst     (areset),
            .wr_en   (s_tvalid[i] & s_tready[i]),
            .wr_data (s_tdata[i]),
            .full    (full[i]),
            .rd_en   (fire),
            .rd_data (m_tdata[i]),
            .empty   (empty[i])
        );
    end

    always_ff @(posedge aclk) begin
        if (areset)
            beat_count <= '0;
        else if (fire)
            beat_count <= beat_count + 32'd1;
    end

endmodule

// File: tb/tb_axis_chan_align.sv
// Directed bench for axis_chan_align: reset, skew, full, backpressure,
// streaming and mid-operation reset with hand-computed expectations.
module tb_axis_chan_align;

    logic             aclk = 1'b0;
    logic             areset;
    logic [1:0]       s_tvalid;
    logic [1:0][31:0] s_tdata;
    logic [1:0]       s_tready;
    logic [1:0]       m_tvalid;
    logic [1:0][31:0] m_tdata;
    logic [1:0]       m_tready;
    logic [31:0]      beat_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0][31:0] exp_d;

    always #5 aclk = ~aclk;

    axis_chan_align #(
        .C_DATA_WIDTH   (32),
        .C_NUM_CHANNELS (2),
        .C_FIFO_DEPTH   (4)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tready   (m_tready),
        .beat_count (beat_count)
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        areset   = 1'b1;
        s_tvalid = 2'b11;
        s_tdata  = '0;
        m_tready = 2'b11;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if (s_tready !== 2'b00 || m_tvalid !== 2'b00 || beat_count !== 32'd0) begin
                n_bad++;
                $display("FAIL reset cyc%0d: rdy=%b vld=%b cnt=%0d, want 00/00/0",
                         c, s_tready, m_tvalid, beat_count);
            end
        end
        areset   = 1'b0;
        s_tvalid = 2'b00;
        step();
        n_cmp++;
        if (s_tready !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_release: rdy=%b want 11", s_tready);
        end
    endtask

    task automatic test_skew();
        m_tready = 2'b11;
        for (int k = 1; k <= 3; k++) begin
            s_tvalid   = 2'b01;
            s_tdata[0] = 32'(k);
            step();
        end
        s_tvalid = 2'b00;
        n_cmp++;
        if (m_tvalid !== 2'b00) begin
            n_bad++;
            $display("FAIL skew_novalid: vld=%b want 00", m_tvalid);
        end
        for (int k = 0; k < 3; k++) begin
            s_tvalid   = 2'b10;
            s_tdata[1] = 32'hA + 32'(k);
            step();
            exp_d[0] = 32'(k + 1);
            exp_d[1] = 32'hA + 32'(k);
            n_cmp++;
            if (m_tvalid !== 2'b11 || m_tdata !== exp_d) begin
                n_bad++;
                $display("FAIL skew_pair%0d: vld=%b data=%h want 11 %h",
                         k, m_tvalid, m_tdata, exp_d);
            end
        end
        s_tvalid = 2'b00;
        step();
        n_cmp++;
        if (m_tvalid !== 2'b00 || beat_count !== 32'd3) begin
            n_bad++;
            $display("FAIL skew_done: vld=%b cnt=%0d want 00 3", m_tvalid, beat_count);
        end
    endtask

    task automatic test_full();
        m_tready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            s_tvalid   = 2'b01;
            s_tdata[0] = 32'h10 + 32'(k);
            step();
        end
        s_tdata[0] = 32'h14;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (s_tready !== 2'b10 || m_tvalid !== 2'b00) begin
                n_bad++;
                $display("FAIL full_hold%0d: rdy=%b vld=%b want 10 00",
                         c, s_tready, m_tvalid);
            end
            step();
        end
        s_tvalid   = 2'b11;
        s_tdata[1] = 32'h55;
        step();
        s_tvalid = 2'b01;
        exp_d[0] = 32'h10;
        exp_d[1] = 32'h55;
        n_cmp++;
        if (m_tvalid !== 2'b11 || m_tdata !== exp_d) begin
            n_bad++;
            $display("FAIL full_pair: vld=%b data=%h want 11 %h", m_tvalid, m_tdata, exp_d);
        end
        step();
        n_cmp++;
        if (beat_count !== 32'd4 || s_tready[0] !== 1'b1 || m_tvalid !== 2'b00) begin
            n_bad++;
            $display("FAIL full_fire: cnt=%0d rdy=%b vld=%b want 4 x1 00",
                     beat_count, s_tready, m_tvalid);
        end
        step();
        s_tvalid = 2'b00;
        n_cmp++;
        if (s_tready[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL full_accept14: rdy0=%b want 0", s_tready[0]);
        end
    endtask

    task automatic test_backpressure();
        m_tready = 2'b00;
        for (int k = 0; k < 4; k++) begin
            s_tvalid   = 2'b10;
            s_tdata[1] = 32'h21 + 32'(k);
            step();
        end
        s_tvalid = 2'b00;
        exp_d[0] = 32'h11;
        exp_d[1] = 32'h21;
        for (int c = 0; c < 13; c++) begin
            if (c == 10) m_tready = 2'b01;
            n_cmp++;
            if (s_tready !== 2'b00 || m_tvalid !== 2'b11 ||
                m_tdata !== exp_d || beat_count !== 32'd4) begin
                n_bad++;
                $display("FAIL bp_hold%0d: rdy=%b vld=%b data=%h cnt=%0d want 00 11 %h 4",
                         c, s_tready, m_tvalid, m_tdata, beat_count, exp_d);
            end
            step();
        end
        m_tready = 2'b11;
        for (int k = 1; k <= 3; k++) begin
            step();
            exp_d[0] = 32'h11 + 32'(k);
            exp_d[1] = 32'h21 + 32'(k);
            n_cmp++;
            if (m_tvalid !== 2'b11 || m_tdata !== exp_d ||
                beat_count !== 32'(4 + k) || s_tready !== 2'b11) begin
                n_bad++;
                $display("FAIL bp_drain%0d: vld=%b data=%h cnt=%0d rdy=%b want 11 %h %0d 11",
                         k, m_tvalid, m_tdata, beat_count, s_tready, exp_d, 4 + k);
            end
        end
        step();
        n_cmp++;
        if (m_tvalid !== 2'b00 || beat_count !== 32'd8) begin
            n_bad++;
            $display("FAIL bp_empty: vld=%b cnt=%0d want 00 8", m_tvalid, beat_count);
        end
    endtask

    task automatic test_streaming();
        areset = 1'b1;
        step();
        areset = 1'b0;
        step();
        m_tready = 2'b00;
        for (int k = 0; k < 2; k++) begin
            s_tvalid   = 2'b11;
            s_tdata[0] = 32'h1000 + 32'(k);
            s_tdata[1] = 32'h2000 + 32'(k);
            step();
        end
        m_tready = 2'b11;
        for (int j = 0; j < 100; j++) begin
            exp_d[0] = 32'h1000 + 32'(j);
            exp_d[1] = 32'h2000 + 32'(j);
            n_cmp++;
            if (m_tvalid !== 2'b11 || m_tdata !== exp_d || s_tready !== 2'b11) begin
                n_bad++;
                $display("FAIL stream%0d: vld=%b data=%h rdy=%b want 11 %h 11",
                         j, m_tvalid, m_tdata, s_tready, exp_d);
            end
            s_tvalid   = 2'b11;
            s_tdata[0] = 32'h1000 + 32'(j + 2);
            s_tdata[1] = 32'h2000 + 32'(j + 2);
            step();
        end
        s_tvalid = 2'b00;
        m_tready = 2'b00;
        exp_d[0] = 32'h1000 + 32'd100;
        exp_d[1] = 32'h2000 + 32'd100;
        n_cmp++;
        if (beat_count !== 32'd100 || m_tdata !== exp_d) begin
            n_bad++;
            $display("FAIL stream_count: cnt=%0d data=%h want 100 %h",
                     beat_count, m_tdata, exp_d);
        end
    endtask

    task automatic test_mid_reset();
        areset = 1'b1;
        step();
        areset = 1'b0;
        step();
        m_tready = 2'b00;
        for (int k = 0; k < 3; k++) begin
            s_tvalid   = (k == 0) ? 2'b11 : 2'b01;
            s_tdata[0] = 32'h400 + 32'(k);
            s_tdata[1] = 32'h500;
            step();
        end
        s_tvalid = 2'b00;
        m_tready = 2'b11;
        areset   = 1'b1;
        #1;
        n_cmp++;
        if (m_tvalid !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_reset_vld: vld=%b want 00", m_tvalid);
        end
        step();
        areset = 1'b0;
        n_cmp++;
        if (m_tvalid !== 2'b00 || beat_count !== 32'd0) begin
            n_bad++;
            $display("FAIL mid_reset_state: vld=%b cnt=%0d want 00 0", m_tvalid, beat_count);
        end
        step();
        s_tvalid   = 2'b11;
        s_tdata[0] = 32'h66;
        s_tdata[1] = 32'h77;
        step();
        s_tvalid = 2'b00;
        exp_d[0] = 32'h66;
        exp_d[1] = 32'h77;
        n_cmp++;
        if (m_tvalid !== 2'b11 || m_tdata !== exp_d) begin
            n_bad++;
            $display("FAIL mid_reset_new: vld=%b data=%h want 11 %h", m_tvalid, m_tdata, exp_d);
        end
        step();
        n_cmp++;
        if (m_tvalid !== 2'b00 || beat_count !== 32'd1) begin
            n_bad++;
            $display("FAIL mid_reset_drain: vld=%b cnt=%0d want 00 1", m_tvalid, beat_count);
        end
    endtask

    initial begin
        test_reset();
        test_skew();
        test_full();
        test_backpressure();
        test_streaming();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_chan_align.md
Name: axis_chan_align

Overview:
Input-side stage that sits directly upstream of the AXI-stream wrapper around the generated `main` pipeline. That wrapper needs all input channels valid in the same cycle. This block takes independent, skewed AXI4-Stream channels (for example, separate memory readers) and buffers each one in a small FIFO. It presents one jointly-valid beat per cycle across all channels, so lane-aligned vectors reach the kernel even when sources arrive at different times.

Parameters:
C_DATA_WIDTH, 32, width of one channel beat (32 * vector width; 512 max).
C_NUM_CHANNELS, 2, number of input channels (1..8).
C_FIFO_DEPTH, 4, entries per channel FIFO; power of two, >= 2.

Ports:
aclk  in  1  clock; all logic on rising edge.
areset  in  1  synchronous, active-high reset.
s_tvalid  in  C_NUM_CHANNELS  per-channel source valid.
s_tdata  in  [C_NUM_CHANNELS][C_DATA_WIDTH]  per-channel source data (packed 2-D).
s_tready  out  C_NUM_CHANNELS  per-channel accept.
m_tvalid  out  C_NUM_CHANNELS  aligned valid to the kernel wrapper; all bits always equal.
m_tdata  out  [C_NUM_CHANNELS][C_DATA_WIDTH]  aligned data; lane i is the head of FIFO i.
m_tready  in  C_NUM_CHANNELS  downstream accept; a transfer requires all bits high.
beat_count  out  32  count of aligned transfers since reset.

Behaviour:
- Reset: one clock and one reset, named aclk/areset; reset is synchronous and active-high. While areset is high:
  - read/write pointers go to 0; s_tready=0; m_tvalid=0; beat_count=0.
  - FIFO memory contents are don't-care.
  - s_tready goes to all-ones on the first edge after areset deasserts.
- Per channel i:
  - push_i = s_tvalid[i] & s_tready[i].
  - s_tready[i] = !full_i, registered.
  - s_tready[i] never depends on s_tvalid or m_tready.
- FIFO: synchronous write, first-word-fall-through read. Pointers are log2(C_FIFO_DEPTH)+1 bits with a wrap bit.
  - full: MSBs differ and LSBs are equal.
  - empty: pointers are equal.
- Alignment: avail = AND over i of !empty_i.
  - m_tvalid = {C_NUM_CHANNELS{avail}}.
  - m_tvalid never depends on m_tready. This is required because the downstream s_tready is combinational on its s_tvalid.
- Fire: fire = avail & (&m_tready). On fire, every FIFO pops one entry in the same cycle, and beat_count increments.
  - No channel ever pops alone.
- Latency: a word pushed at edge N is visible at the FIFO head after edge N. The earliest m_tvalid is cycle N+1 if all other channels are already non-empty.
- Full: s_tready[i] drops after the edge that makes occupancy equal C_FIFO_DEPTH.
  - Full FIFO with fire in the same cycle: s_tready is already 0, so no push occurs. s_tready returns to 1 on the next edge.
  - A full channel waits for the slowest channel and never drops or overwrites data.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged and order is preserved.
- Empty: a push to an empty FIFO cannot fire in the same cycle; there is no bypass path.
- m_tdata: while m_tvalid=1 and fire=0, m_tdata is held stable. When m_tvalid=0, m_tdata is don't-care.
- beat_count wraps modulo 2^32 with no saturation.
- Reset mid-operation: all buffered data is discarded and no partial beat is emitted.

Decomposition:
- Shared package tybec_axis_pkg holds:
  - TY_MAX_STREAMW=512 and the default data width derived from TY_GVECT.
  - typedef logic [C_DATA_WIDTH-1:0] ty_beat_t.
  - a clog2-based pointer-width function.
- One sub-module, tybec_sync_fifo (parameters width and depth; ports wr_en/wr_data/full, rd_en/rd_data/empty), instantiated C_NUM_CHANNELS times in a generate loop.
- The top level holds only the alignment/fire logic and beat_count.

Test Plan:
1. Reset: areset=1 for 3 cycles with s_tvalid=2'b11 -> s_tready=00, m_tvalid=00, beat_count=0 throughout; s_tready=11 on the first cycle after release.
2. Skew, m_tready=11 held throughout:
   - Stimulus: ch0 pushes 0x1,0x2,0x3 on edges 0-2; ch1 pushes 0xA,0xB,0xC on edges 3-5.
   - Response: m_tvalid first high after edge 3; output pairs (1,A),(2,B),(3,C) fire on consecutive cycles; beat_count=3.
3. Full, ch1 idle:
   - Stimulus: ch0 offers 0x10..0x14.
   - Response: 4 words are accepted; s_tready[0]=0 with 0x14 held on s_tdata; m_tvalid stays 0.
   - Then ch1 pushes one word -> pair (0x10, w) fires and ch0 accepts 0x14 on the following cycle.
4. Backpressure:
   - Stimulus: both FIFOs full, m_tready=00 for 10 cycles.
   - Response: m_tdata stable, m_tvalid=1, no pops.
   - With m_tready=01 -> still no fire. With m_tready=11 -> 4 beats out back-to-back in order.
5. Streaming, m_tready=11:
   - Stimulus: both channels push continuously from occupancy 2.
   - Response: occupancy stays 2; 100 beats out with data order matching input; beat_count=100.
6. Mid-reset: with occupancy 3/1, assert areset for 1 cycle -> next cycle both FIFOs empty, m_tvalid=0, beat_count=0; old data never appears at the output.
